// File: rtl/if_pkg.sv
// Shared definitions for the IF/ID fetch queue.
//   DATA_W    : default width of instruction and PC words
//   NOP_INSTR : instruction encoding presented to decode when the queue is empty
//   if_entry_t: one buffered {pc4, instr} pair, pc4 in the upper half
package if_pkg;

  localparam int DATA_W = 16;

  localparam logic [DATA_W-1:0] NOP_INSTR = 16'h0000;

  typedef struct packed {
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] instr;
  } if_entry_t;

endpackage : if_pkg

// File: rtl/if_id_queue_if.sv
// Valid/ready stream carrying one {pc4, instr} pair per transfer.
//   valid : producer presents a pair
//   pc4   : PC+4 of the instruction
//   instr : instruction word
//   ready : consumer accepts the pair this cycle
// master = producer side, slave = consumer side.
interface if_id_queue_if
  import if_pkg::*;
#(
  parameter int W = if_pkg::DATA_W
);

  logic         valid;
  logic [W-1:0] pc4;
  logic [W-1:0] instr;
  logic         ready;

  modport master (output valid, output pc4, output instr, input ready);
  modport slave  (input valid, input pc4, input instr, output ready);

endinterface : if_id_queue_if

// File: rtl/if_queue_ram.sv
// DEPTH x W register array for the fetch queue.
//   clock : write clock
//   we    : write enable
//   waddr : write slot
//   wdata : write data
//   raddr : read slot
//   rdata : read data, combinational from raddr
module if_queue_ram #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // NOTE: storage is deliberately not reset; the queue forces its outputs to
  // zero when empty, so stale slots can never be seen.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : if_queue_ram

// File: rtl/if_id_queue.sv
// IF/ID fetch queue: buffers {PC+4, instruction} pairs from fetch and presents
// them to decode, stalls fetch when full, and discards everything on a flush.
//   clock      : rising-edge clock
//   reset_n    : synchronous active-low reset, overrides flush and handshakes
//   in_if      : fetch side (slave); ready low stalls the PC
//   out_if     : decode side (master); pc4/instr read as 0 when empty
//   flush      : redirect, empties the queue next cycle
//   level      : current occupancy
//   drop_count : saturating count of entries discarded by flush
module if_id_queue
  import if_pkg::*;
#(
  parameter int DATA_W = if_pkg::DATA_W,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  if_id_queue_if.slave     in_if,
  if_id_queue_if.master    out_if,
  input  logic             flush,
  output logic [LVL_W-1:0] level,
  output logic [CNT_W-1:0] drop_count
);

  localparam int ENTRY_W = 2 * DATA_W;
  // Wide enough for drop_count + level without overflow.
  localparam int SUM_W   = ((CNT_W > LVL_W) ? CNT_W : LVL_W) + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic               full, empty;
  logic               push, pop;
  logic [SUM_W-1:0]   drop_sum;
  logic [ENTRY_W-1:0] head;

  // Ready and valid depend on stored state only: no pass-through when full.
  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);

  assign in_if.ready  = !full;
  assign out_if.valid = !empty;

  // Handshakes in a flush cycle belong to the wrong path and are dropped.
  assign push = in_if.valid && !full && !flush;
  assign pop  = out_if.ready && !empty && !flush;

  assign drop_sum = SUM_W'(drop_q) + SUM_W'(level_q);

  // NOTE: every always_comb target is defaulted first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    drop_d   = drop_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      if (drop_sum > SUM_W'({CNT_W{1'b1}})) begin
        drop_d = '1;
      end else begin
        drop_d = drop_sum[CNT_W-1:0];
      end
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      // Simultaneous push and pop leaves the level unchanged.
      if (push && !pop) begin
        level_d = level_q + LVL_W'(1);
      end else if (pop && !push) begin
        level_d = level_q - LVL_W'(1);
      end
    end
  end

  // NOTE: reset is synchronous and sampled on the clock edge; sequential
  // state uses non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      drop_q   <= drop_d;
    end
  end

  if_queue_ram #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_ram (
    .clock (clock),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata ({in_if.pc4, in_if.instr}),
    .raddr (rd_ptr_q),
    .rdata (head)
  );

  assign out_if.pc4   = empty ? '0 : head[ENTRY_W-1:DATA_W];
  assign out_if.instr = empty ? DATA_W'(NOP_INSTR) : head[DATA_W-1:0];

  assign level      = level_q;
  assign drop_count = drop_q;

endmodule : if_id_queue
